exe_div: RTL and testbench
==========================

Name: exe_div

Overview:
- Iterative 32-bit integer divider in the EXE stage, fed by the ID/EXE pipeline register. It executes MIPS DIV and DIVU.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Raises a stall request to the pipeline controller while busy, so the ID/EXE register holds the instruction until the quotient and remainder are ready for the HI/LO write in the EXE/MEM register.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width (counts 0..WIDTH).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_start  in  1  divide requested by the current EXE instruction (decoded from ALUControl).
- i_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled only on start acceptance.
- i_dividend  in  WIDTH  rs value (o_da of ID/EXE); sampled only on start acceptance.
- i_divisor  in  WIDTH  rt value (o_db of ID/EXE); sampled only on start acceptance.
- i_annul  in  1  pipeline flush (exception/eret); aborts any operation.
- i_hold  in  1  downstream stall (MEM or later stopped); keeps the result in DONE.
- o_lo  out  WIDTH  quotient.
- o_hi  out  WIDTH  remainder.
- o_done  out  1  result valid this cycle.
- o_busy  out  1  state is BUSY or DZERO.
- o_stall_req  out  1  request to stall PC/IF/ID/EXE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, o_lo=0, o_hi=0, o_done=0, o_busy=0. o_stall_req is 0 because it is combinational on state and i_start.
- States: IDLE, DZERO, BUSY, DONE.
- IDLE, i_start=1, i_annul=0, divisor==0: go to DZERO.
- IDLE, i_start=1, i_annul=0, divisor!=0: go to BUSY. Latch operands:
  - signed: |dividend| and |divisor| as unsigned WIDTH magnitudes; |0x80000000| = 0x80000000.
  - also latch neg_q = sign(dividend) XOR sign(divisor), and neg_r = sign(dividend).
  - counter=0; partial remainder=0.
- BUSY: each cycle, shift {rem, quo} left 1 and trial-subtract the divisor from rem. If no borrow, keep the difference and set the quotient LSB to 1. Increment counter. When counter reaches WIDTH-1 and that iteration completes, go to DONE, so BUSY lasts exactly WIDTH cycles.
- BUSY to DONE transition: apply sign correction (quotient negated if neg_q; remainder negated if neg_r) and register the results into o_lo/o_hi.
- DZERO: one cycle. Next state DONE with o_lo=0, o_hi=0. The result is architecturally undefined but is fixed to 0 for determinism.
- DONE: o_done=1. o_lo/o_hi stable.
  - i_hold=1: remain in DONE.
  - i_hold=0: go to IDLE next edge. o_lo/o_hi keep their values; o_done=0.
- o_stall_req = i_start & ~i_annul & (state != DONE).
  - Asserted in the same cycle the divide instruction first appears in EXE.
  - Deasserted in DONE so the instruction advances with the result.
- Latency, start seen in IDLE at edge T0: non-zero divisor gives DONE at T0+WIDTH+1 (T0+33); zero divisor gives DONE at T0+2.
- Back-to-back: a new divide in EXE the cycle after DONE (state IDLE, i_start=1) starts normally. The old instruction has already left EXE, so it is never restarted.
- i_annul=1 in any state: next edge goes to IDLE, o_done=0, counter=0; o_lo/o_hi unchanged. i_annul overrides i_start and i_hold in the same cycle.
- Operands are never re-sampled during BUSY; input changes have no effect until IDLE.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: o_lo=0x80000000, o_hi=0. No exception.
- Asynchronous reset asserted mid-BUSY: immediate return to reset values; no partial result is visible.

Test Plan:
- Unsigned 100 / 7, i_start held high → o_stall_req=1 for 33 cycles; o_done=1 at T0+33 with o_lo=14, o_hi=2; o_stall_req=0 in that cycle.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) → o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF. Signed 7 / -2 → o_lo=0xFFFFFFFD, o_hi=1.
- Divisor 0, any dividend → DONE at T0+2, o_lo=0, o_hi=0; signed 0x80000000 / 0xFFFFFFFF → o_lo=0x80000000, o_hi=0.
- Start 0xFFFFFFFF / 3 unsigned, assert i_annul at cycle 10 → IDLE next edge, o_done never asserts, o_stall_req=0 once i_start drops.
- Result 1000 / 10 with i_hold=1 for 3 cycles in DONE → o_done=1 and o_lo=100 for 4 consecutive cycles, then IDLE; a second divide 9 / 4 presented the next cycle completes with o_lo=2, o_hi=1.
- Assert reset low mid-BUSY (cycle 15) → all outputs 0 immediately; after release, 50 / 5 completes correctly with o_lo=10, o_hi=0.

Source files
------------

// File: rtl/exe_div_if.sv
// Handshake bundle between the ID/EXE stage and the iterative divider.
interface exe_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic             i_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             i_annul;
  logic             i_hold;
  logic [WIDTH-1:0] o_lo;
  logic [WIDTH-1:0] o_hi;
  logic             o_done;
  logic             o_busy;
  logic             o_stall_req;

  modport master (
    output i_start, i_signed, i_dividend, i_divisor, i_annul, i_hold,
    input  o_lo, o_hi, o_done, o_busy, o_stall_req
  );

  modport slave (
    input  i_start, i_signed, i_dividend, i_divisor, i_annul, i_hold,
    output o_lo, o_hi, o_done, o_busy, o_stall_req
  );
endinterface

// File: rtl/exe_div.sv
// Radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.
// Produces one quotient bit per cycle and stalls the front of the pipe while busy.
module exe_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  exe_div_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DZERO,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;
  logic             last_iter;

  // Trial subtraction is WIDTH+1 bits wide: the shifted remainder can exceed
  // WIDTH bits when the divisor has its MSB set.
  always_comb begin
    trial  = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    rem_nx = '0;
    quo_nx = '0;
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
    quo_fix = neg_q ? ('0 - quo_nx) : quo_nx;
    rem_fix = neg_r ? ('0 - rem_nx) : rem_nx;
  end

  always_comb begin
    a_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
    b_neg = bus.i_signed & bus.i_divisor[WIDTH-1];
    a_mag = a_neg ? ('0 - bus.i_dividend) : bus.i_dividend;
    b_mag = b_neg ? ('0 - bus.i_divisor)  : bus.i_divisor;
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (bus.i_annul) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            busy_q <= 1'b1;
            if (bus.i_divisor == '0) begin
              state <= S_DZERO;
            end else begin
              state <= S_BUSY;
              cnt   <= '0;
              rem   <= '0;
              quo   <= a_mag;
              dvsr  <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        S_DZERO: begin
          state  <= S_DONE;
          lo_q   <= '0;
          hi_q   <= '0;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        S_BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state  <= S_DONE;
            lo_q   <= quo_fix;
            hi_q   <= rem_fix;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        S_DONE: begin
          if (!bus.i_hold) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_lo        = lo_q;
  assign bus.o_hi        = hi_q;
  assign bus.o_done      = done_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_stall_req = bus.i_start & ~bus.i_annul & (state != S_DONE);

endmodule

// File: tb/tb_exe_div.sv
// Directed bench for exe_div with a result scoreboard and an arithmetic reference model.
module tb_exe_div;

  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
  } res_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  res_t sb[$];

  exe_div_if #(.WIDTH(WIDTH)) bus ();

  exe_div #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input bit sgn, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    res_t r;
    int   sa;
    int   sb_;
    if (b == '0) begin
      r.lo = '0;
      r.hi = '0;
    end else if (!sgn) begin
      r.lo = a / b;
      r.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.lo = 32'h8000_0000;
      r.hi = '0;
    end else begin
      sa   = $signed(a);
      sb_  = $signed(b);
      r.lo = sa / sb_;
      r.hi = sa % sb_;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge; the combinational stall must rise immediately.
  task automatic start_div(input bit sgn, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input bit push);
    bus.i_start    = 1'b1;
    bus.i_signed   = sgn;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    if (push) sb.push_back(model(sgn, a, b));
    #1;
    check("stall_on_start", {31'b0, bus.o_stall_req}, 32'd1);
  endtask

  // Wait for o_done with a bound, scrambling operands to prove they are not re-sampled.
  task automatic wait_done(input int exp_lat, input string tag);
    int   k;
    bit   seen;
    int   stall_cnt;
    res_t e;
    k = 0;
    seen = 1'b0;
    stall_cnt = 1;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
      if (bus.o_stall_req) stall_cnt++;
      bus.i_dividend = $urandom;
      bus.i_divisor  = $urandom;
      bus.i_signed   = $urandom_range(0, 1);
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_stall_cycles"}, stall_cnt, exp_lat);
    check({tag, "_stall_in_done"}, {31'b0, bus.o_stall_req}, 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_lo"}, bus.o_lo, e.lo);
      check({tag, "_hi"}, bus.o_hi, e.hi);
    end else begin
      check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end
  endtask

  // Instruction leaves EXE: drop start while DONE, confirm return to IDLE.
  task automatic retire(input string tag);
    bus.i_start = 1'b0;
    @(negedge clk);
    check({tag, "_done_clear"}, {31'b0, bus.o_done}, 32'd0);
  endtask

  typedef struct {
    bit               sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.i_start = 1'b0;
    bus.i_signed = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor = '0;
    bus.i_annul = 1'b0;
    bus.i_hold = 1'b0;

    @(negedge clk);
    check("rst_lo", bus.o_lo, 32'd0);
    check("rst_hi", bus.o_hi, 32'd0);
    check("rst_done", {31'b0, bus.o_done}, 32'd0);
    check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    check("rst_stall", {31'b0, bus.o_stall_req}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    vecs.push_back('{1'b0, 32'd100,        32'd7,          33});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'h2,          33});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  33});
    vecs.push_back('{1'b0, 32'd12345,      32'd0,          2});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'd0,          2});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  33});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  33});
    vecs.push_back('{1'b0, 32'hDEAD_BEEF,  32'd1,          33});

    foreach (vecs[i]) begin
      start_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b1);
      wait_done(vecs[i].lat, $sformatf("vec%0d", i));
      retire($sformatf("vec%0d", i));
    end

    // Flush mid-operation: start must be ignored and no result produced.
    start_div(1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    bus.i_annul = 1'b1;
    #1;
    check("annul_stall_masked", {31'b0, bus.o_stall_req}, 32'd0);
    @(negedge clk);
    check("annul_busy", {31'b0, bus.o_busy}, 32'd0);
    bus.i_annul = 1'b0;
    bus.i_start = 1'b0;
    #1;
    check("annul_stall_idle", {31'b0, bus.o_stall_req}, 32'd0);
    begin
      bit any_done;
      any_done = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.o_done) any_done = 1'b1;
      end
      check("annul_never_done", {31'b0, any_done}, 32'd0);
    end

    // Downstream hold keeps the result for four DONE cycles, then back-to-back divide.
    bus.i_hold = 1'b1;
    start_div(1'b0, 32'd1000, 32'd10, 1'b1);
    wait_done(33, "hold");
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("hold_done_%0d", j), {31'b0, bus.o_done}, 32'd1);
      check($sformatf("hold_lo_%0d", j), bus.o_lo, 32'd100);
    end
    bus.i_hold = 1'b0;
    retire("hold");
    check("hold_lo_kept", bus.o_lo, 32'd100);
    start_div(1'b0, 32'd9, 32'd4, 1'b1);
    wait_done(33, "b2b");
    retire("b2b");

    // Asynchronous reset mid-BUSY wipes everything immediately.
    start_div(1'b0, 32'd12345, 32'd17, 1'b0);
    repeat (15) @(negedge clk);
    bus.i_start = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_lo", bus.o_lo, 32'd0);
    check("midrst_hi", bus.o_hi, 32'd0);
    check("midrst_done", {31'b0, bus.o_done}, 32'd0);
    check("midrst_busy", {31'b0, bus.o_busy}, 32'd0);
    check("midrst_stall", {31'b0, bus.o_stall_req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_div(1'b0, 32'd50, 32'd5, 1'b1);
    wait_done(33, "post_rst");
    retire("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
